// File: rtl/sysbus_mem_responder_if.sv
// sysbus_mem_responder_if: request/response signals of the main system bus
interface sysbus_mem_responder_if #(
    parameter int DW = 64,
    parameter int TW = 13
) ();
    logic          main_bus_reqcyc;
    logic [DW-1:0] main_bus_req;
    logic [TW-1:0] main_bus_reqtag;
    logic          main_bus_reqack;
    logic          main_bus_respcyc;
    logic [DW-1:0] main_bus_resp;
    logic [TW-1:0] main_bus_resptag;
    logic          main_bus_respack;
    modport master (
        output main_bus_reqcyc, main_bus_req, main_bus_reqtag, main_bus_respack,
        input  main_bus_reqack, main_bus_respcyc, main_bus_resp, main_bus_resptag
    );
    modport slave (
        input  main_bus_reqcyc, main_bus_req, main_bus_reqtag, main_bus_respack,
        output main_bus_reqack, main_bus_respcyc, main_bus_resp, main_bus_resptag
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: line-granular memory target on the main system bus
module sysbus_mem_responder #(
    parameter int         BUS_DATA_WIDTH = 64,
    parameter int         BUS_TAG_WIDTH  = 13,
    parameter logic [3:0] DEV_MEMORY     = 4'h1,
    parameter int         MEM_LINES      = 256,
    parameter int         READ_LATENCY   = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    sysbus_mem_responder_if.slave             bus,
    input  logic                              init_we,
    input  logic [$clog2(MEM_LINES*8)-1:0]    init_addr,
    input  logic [BUS_DATA_WIDTH-1:0]         init_data,
    output logic                              busy
);
    localparam int LW   = $clog2(MEM_LINES);
    localparam int LATW = $clog2(READ_LATENCY + 1);
    typedef enum logic [2:0] {IDLE, ACCEPT, RDLAT, RDBEAT, WRDATA, WRDONE} state_t;
    state_t                     state_q, state_d;
    logic [LW-1:0]              line_q, line_d;
    logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [2:0]                 beat_q, beat_d;
    logic [LATW-1:0]            lat_q, lat_d;
    logic                       reqack_q, respcyc_q;
    logic [BUS_DATA_WIDTH-1:0]  resp_q;
    logic [BUS_TAG_WIDTH-1:0]   resptag_q;
    logic [BUS_DATA_WIDTH-1:0]  mem [MEM_LINES*8];
    logic                       hit, mem_we, resp_on;
    logic [LW+2:0]              mem_waddr;
    logic [BUS_DATA_WIDTH-1:0]  mem_wdata;

    assign hit = bus.main_bus_reqcyc && bus.main_bus_reqtag[BUS_TAG_WIDTH-2 -: 4] == DEV_MEMORY;
    assign busy = state_q != IDLE;
    assign bus.main_bus_reqack   = reqack_q;
    assign bus.main_bus_respcyc  = respcyc_q;
    assign bus.main_bus_resp     = resp_q;
    assign bus.main_bus_resptag  = resptag_q;

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        tag_d     = tag_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        mem_we    = 1'b0;
        mem_waddr = init_addr;
        mem_wdata = init_data;
        case (state_q)
            IDLE: begin
                mem_we = init_we;
                if (hit) begin
                    state_d = ACCEPT;
                    line_d  = bus.main_bus_req[6 +: LW];
                    tag_d   = bus.main_bus_reqtag;
                end
            end
            ACCEPT: begin
                state_d = tag_q[BUS_TAG_WIDTH-1] ? RDLAT : WRDATA;
                lat_d   = LATW'(1);
                beat_d  = 3'd0;
            end
            RDLAT: begin
                lat_d = lat_q + LATW'(1);
                if (lat_q >= LATW'(READ_LATENCY - 1)) begin
                    state_d = RDBEAT;
                    beat_d  = 3'd0;
                end
            end
            RDBEAT: if (bus.main_bus_respack) begin
                beat_d  = beat_q + 3'd1;
                state_d = beat_q == 3'd7 ? IDLE : RDBEAT;
            end
            WRDATA: if (bus.main_bus_reqcyc) begin
                mem_we    = 1'b1;
                mem_waddr = {line_q, beat_q};
                mem_wdata = bus.main_bus_req;
                beat_d    = beat_q + 3'd1;
                state_d   = beat_q == 3'd7 ? WRDONE : WRDATA;
            end
            WRDONE: state_d = bus.main_bus_respack ? IDLE : WRDONE;
            default: state_d = IDLE;
        endcase
        resp_on = state_d == RDBEAT || state_d == WRDONE;
    end

    // Memory contents survive reset, so the array lives outside the reset domain
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            line_q    <= '0;
            tag_q     <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            reqack_q  <= state_d == ACCEPT;
            respcyc_q <= resp_on;
            resp_q    <= state_d == RDBEAT ? mem[{line_d, beat_d}] : '0;
            resptag_q <= resp_on ? tag_d : '0;
        end
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: scoreboard bench for the system bus memory responder
module tb_sysbus_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init_we = 1'b0;
    logic [10:0] init_addr = '0;
    logic [63:0] init_data = '0;
    logic        busy;
    int          vectors = 0;
    int          miscompares = 0;
    int          beats = 0;
    typedef struct {
        logic [63:0] data;
        logic [12:0] tag;
    } exp_t;
    exp_t        sb[$];
    logic [63:0] model [2048];
    logic        prev_cyc = 1'b0;
    logic        prev_ack = 1'b0;
    logic [63:0] prev_resp = '0;

    sysbus_mem_responder_if #(.DW(64), .TW(13)) bus ();

    sysbus_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.main_bus_respcyc && prev_cyc && !prev_ack) chk("hold", bus.main_bus_resp, prev_resp);
            if (bus.main_bus_respcyc && bus.main_bus_respack) begin
                beats++;
                if (sb.size() == 0) chk("spurious_beat", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp", bus.main_bus_resp, e.data);
                    chk("resptag", {51'd0, bus.main_bus_resptag}, {51'd0, e.tag});
                end
            end
            prev_cyc  = bus.main_bus_respcyc;
            prev_ack  = bus.main_bus_respack;
            prev_resp = bus.main_bus_resp;
        end else prev_cyc = 1'b0;
    end

    task automatic backdoor(input logic [10:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        init_we = 1'b1; init_addr = a; init_data = d; model[a] = d;
        @(posedge clk); #1;
        init_we = 1'b0;
    endtask

    task automatic issue(input logic [63:0] addr, input logic [12:0] tag);
        @(posedge clk); #1;
        bus.main_bus_reqcyc = 1'b1; bus.main_bus_req = addr; bus.main_bus_reqtag = tag;
        @(posedge clk); #1;
        bus.main_bus_reqcyc = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (toggle) bus.main_bus_respack = ~bus.main_bus_respack;
        end
        chk("busy_drop", {63'd0, busy}, 64'd0);
        chk("respcyc_idle", {63'd0, bus.main_bus_respcyc}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        bus.main_bus_respack = 1'b1;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input bit toggle, input bit intrude);
        int n = 0;
        bus.main_bus_respack = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back('{model[{addr[13:6], 3'(i)}], tag});
        issue(addr, tag);
        chk("reqack", {63'd0, bus.main_bus_reqack}, 64'd1);
        while (!bus.main_bus_respcyc && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk("reqack_pulse", {63'd0, bus.main_bus_reqack}, 64'd0);
        end
        chk("rd_latency", 64'(n), 64'd3);
        if (intrude) begin
            bus.main_bus_respack = 1'b0;
            issue(64'h40, 13'h1100);
            chk("intrude_noack", {63'd0, bus.main_bus_reqack}, 64'd0);
            bus.main_bus_respack = 1'b1;
        end
        drain(toggle);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] base, input int bubble);
        bus.main_bus_respack = 1'b1;
        sb.push_back('{64'd0, tag});
        issue(addr, tag);
        chk("wr_reqack", {63'd0, bus.main_bus_reqack}, 64'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            bus.main_bus_reqcyc = 1'b1;
            bus.main_bus_req = base + 64'(i);
            model[{addr[13:6], 3'(i)}] = base + 64'(i);
            @(posedge clk); #1;
            bus.main_bus_reqcyc = 1'b0;
            if (i == bubble) begin
                @(posedge clk); #1;
            end
        end
        drain(1'b0);
    endtask

    initial begin
        int start;
        int n;
        bus.main_bus_reqcyc = 1'b0;
        bus.main_bus_req = '0;
        bus.main_bus_reqtag = '0;
        bus.main_bus_respack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reqack", {63'd0, bus.main_bus_reqack}, 64'd0);
        chk("rst_respcyc", {63'd0, bus.main_bus_respcyc}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_resp", bus.main_bus_resp, 64'd0);
        chk("rst_resptag", {51'd0, bus.main_bus_resptag}, 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) backdoor({8'd2, 3'(i)}, 64'h100 + 64'(i));
        do_read(64'h80, 13'h1100, 1'b0, 1'b0);
        do_read(64'h80, 13'h1100, 1'b1, 1'b0);
        do_write(64'h40, 13'h0100, 64'hA0, 3);
        do_read(64'h40, 13'h1155, 1'b0, 1'b0);
        do_read(64'h4080, 13'h11AB, 1'b0, 1'b0);
        issue(64'h80, 13'h1200);
        chk("foreign_noack", {63'd0, bus.main_bus_reqack}, 64'd0);
        chk("foreign_busy", {63'd0, busy}, 64'd0);
        do_read(64'h80, 13'h1177, 1'b0, 1'b1);
        // Abort a read mid-line: hit reset while beat 4 is on the bus
        for (int i = 0; i < 8; i++) sb.push_back('{model[{8'd2, 3'(i)}], 13'h1100});
        bus.main_bus_respack = 1'b1;
        start = beats;
        issue(64'h80, 13'h1100);
        n = 0;
        while (beats < start + 4 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_beat4", bus.main_bus_resp, 64'h104);
        #1 reset = 1'b0;
        #1;
        chk("abort_respcyc", {63'd0, bus.main_bus_respcyc}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_reqack", {63'd0, bus.main_bus_reqack}, 64'd0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_idle", {63'd0, bus.main_bus_respcyc}, 64'd0);
        do_read(64'h80, 13'h1100, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
